// File: rtl/din_buf_pkg.sv
// din_buf shared types: FSM encoding and default buffer geometry.
// Overwrite mode is selected by DIN_BUF_OVERWRITE_EN.
package din_buf_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int LOG2_DEPTH_DEF = 2;
  localparam int DEPTH = 1 << LOG2_DEPTH_DEF;

endpackage

// File: rtl/din_buf_if.sv
// din_buf bus: sample handshake, RAM ports, consumer side, status.
// Overwrite mode is selected by DIN_BUF_OVERWRITE_EN.
interface din_buf_if #(
  parameter int DW = 16,
  parameter int AW = 2
);

  logic          DIN_VALID;
  logic [DW-1:0] DIN_DATA;
  logic          DIN_READY;
  logic [AW-1:0] DIN_IN_WADR;
  logic          DIN_IN_WEN;
  logic [DW-1:0] DIN_IN_WDAT;
  logic [AW-1:0] DIN_OUT_RADR;
  logic          DOUT_VALID;
  logic          DOUT_POP;
  logic [AW:0]   NUM_IN_BUF;
  logic          OVERFLOW;

  modport master (
    output DIN_VALID, DIN_DATA, DOUT_POP,
    input  DIN_READY, DIN_IN_WADR,
    input  DIN_IN_WEN, DIN_IN_WDAT,
    input  DIN_OUT_RADR, DOUT_VALID,
    input  NUM_IN_BUF, OVERFLOW
  );

  modport slave (
    input  DIN_VALID, DIN_DATA, DOUT_POP,
    output DIN_READY, DIN_IN_WADR,
    output DIN_IN_WEN, DIN_IN_WDAT,
    output DIN_OUT_RADR, DOUT_VALID,
    output NUM_IN_BUF, OVERFLOW
  );

endinterface

// File: rtl/din_buf_ptr.sv
// din_buf wrapping pointer: advances on inc, wraps at 2**W.
// Overwrite mode is selected by DIN_BUF_OVERWRITE_EN.
module din_buf_ptr #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/din_buf_ctrl.sv
// Input sample RAM controller: circular pointers, count, prime FSM.
// Define DIN_BUF_OVERWRITE_EN to drop the oldest sample when full.
module din_buf_ctrl
  import din_buf_pkg::*;
#(
  parameter int DIN_WORDLENGTH = 16,
  parameter int LOG2_DEPTH = $clog2(DEPTH),
  parameter int PRIME_LEVEL = 2
) (
  input logic     CLK,
  input logic     RESET,
  din_buf_if.slave bus
);

  localparam logic [LOG2_DEPTH:0] FULL_CNT =
    {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [LOG2_DEPTH:0] PRIME_CNT =
    PRIME_LEVEL[LOG2_DEPTH:0];

  state_t state;
  state_t state_nxt;

  logic [LOG2_DEPTH:0]   cnt;
  logic [LOG2_DEPTH:0]   cnt_nxt;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [DIN_WORDLENGTH-1:0] wdat;

  logic full;
  logic ready;
  logic dvalid;
  logic accept;
  logic pop;
  logic rd_inc;
  logic grow;

  assign full   = (cnt == FULL_CNT);
  assign dvalid = (state == RUN) && (cnt != '0);
  // Gate with RESET so no RAM write escapes mid-reset.
  assign accept = bus.DIN_VALID && ready && !RESET;
  assign pop    = bus.DOUT_POP && dvalid;
  assign wdat   = bus.DIN_DATA;

`ifdef DIN_BUF_OVERWRITE_EN
  logic drop;
  logic ovf;

  assign ready  = 1'b1;
  assign drop   = accept && full && !pop;
  assign rd_inc = pop || drop;
  assign grow   = accept && !pop && !drop;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
  end

  assign bus.OVERFLOW = ovf;
`else
  assign ready  = !full;
  assign rd_inc = pop;
  assign grow   = accept && !pop;
  assign bus.OVERFLOW = 1'b0;
`endif

  din_buf_ptr #(.W(LOG2_DEPTH)) u_wr_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (accept),
    .ptr   (wr_ptr)
  );

  din_buf_ptr #(.W(LOG2_DEPTH)) u_rd_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (rd_inc),
    .ptr   (rd_ptr)
  );

  always_comb begin
    cnt_nxt = cnt;
    if (grow)
      cnt_nxt = cnt + 1'b1;
    else if (pop && !accept)
      cnt_nxt = cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PRIME:
        if (cnt_nxt >= PRIME_CNT)
          state_nxt = RUN;
      RUN:
        if (cnt_nxt == '0)
          state_nxt = PRIME;
      default:
        state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt   <= '0;
      state <= PRIME;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  assign bus.DIN_READY    = ready;
  assign bus.DIN_IN_WEN   = accept;
  assign bus.DIN_IN_WADR  = wr_ptr;
  assign bus.DIN_IN_WDAT  = wdat;
  assign bus.DIN_OUT_RADR = rd_ptr;
  assign bus.DOUT_VALID   = dvalid;
  assign bus.NUM_IN_BUF   = cnt;

endmodule

// File: tb/tb_din_buf_ctrl.sv
// Bench for din_buf_ctrl: queue model, RAM model, scoreboard monitor.
// Build with DIN_BUF_OVERWRITE_EN to exercise overwrite mode.
module tb_din_buf_ctrl;

  localparam int D  = 4;
  localparam int PL = 2;

`ifdef DIN_BUF_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  din_buf_if #(.DW(16), .AW(2)) bus ();

  din_buf_ctrl #(
    .DIN_WORDLENGTH (16),
    .LOG2_DEPTH     (2),
    .PRIME_LEVEL    (PL)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [15:0] ram [D];

  always @(posedge CLK)
    if (bus.DIN_IN_WEN)
      ram[bus.DIN_IN_WADR] <= bus.DIN_IN_WDAT;

  logic [15:0] sb_q [$];
  int n_chk = 0;
  int n_pass = 0;

  int m_n, m_wr, m_rd;
  bit m_run, m_ovf;

  function automatic void chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
  endfunction

  function automatic bit m_ready();
    return OVW || (m_n != D);
  endfunction

  function automatic bit m_valid();
    return m_run && (m_n != 0);
  endfunction

  always @(negedge CLK) begin
    logic [15:0] e;
    if (!RESET && bus.DOUT_VALID && bus.DOUT_POP) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_pop: got pop want none at %0t",
                 $time);
      end else begin
        e = sb_q.pop_front();
        chk("rdat", ram[bus.DIN_OUT_RADR], e);
      end
    end
  end

  task automatic chk_regs();
    chk("ready", bus.DIN_READY, m_ready());
    chk("dvalid", bus.DOUT_VALID, m_valid());
    chk("num", bus.NUM_IN_BUF, m_n);
    chk("wadr", bus.DIN_IN_WADR, m_wr);
    chk("radr", bus.DIN_OUT_RADR, m_rd);
    chk("ovf", bus.OVERFLOW, m_ovf);
  endtask

  task automatic step(
    input bit v,
    input logic [15:0] d,
    input bit p
  );
    bit acc, pp, drop;
    chk_regs();
    bus.DIN_VALID = v;
    bus.DIN_DATA  = d;
    bus.DOUT_POP  = p;
    acc = v && m_ready();
    pp  = p && m_valid();
    @(negedge CLK);
    chk("ready_comb", bus.DIN_READY, m_ready());
    chk("wen", bus.DIN_IN_WEN, acc);
    if (acc) begin
      chk("wdat", bus.DIN_IN_WDAT, d);
      sb_q.push_back(d);
    end
    @(posedge CLK);
    drop = OVW && acc && (m_n == D) && !pp;
    if (acc) m_wr = (m_wr + 1) % D;
    if (pp || drop) m_rd = (m_rd + 1) % D;
    if (drop) begin
      m_ovf = 1'b1;
      void'(sb_q.pop_front());
    end else begin
      m_n = m_n + int'(acc) - int'(pp);
    end
    if (!m_run && m_n >= PL) m_run = 1'b1;
    else if (m_run && m_n == 0) m_run = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    chk("rst_ready", bus.DIN_READY, 1);
    chk("rst_wen", bus.DIN_IN_WEN, 0);
    chk("rst_dvalid", bus.DOUT_VALID, 0);
    chk("rst_num", bus.NUM_IN_BUF, 0);
    chk("rst_wadr", bus.DIN_IN_WADR, 0);
    chk("rst_radr", bus.DIN_OUT_RADR, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    bus.DIN_VALID = 1'b0;
    bus.DOUT_POP  = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    m_n = 0; m_wr = 0; m_rd = 0;
    m_run = 1'b0; m_ovf = 1'b0;
    sb_q.delete();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.DIN_VALID = 1'b1;
    bus.DIN_DATA  = 16'h0;
    bus.DOUT_POP  = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();

    step(1, 16'h0011, 0);
    step(1, 16'h0022, 0);
    step(1, 16'h0033, 0);
    step(1, 16'h0044, 0);
    step(1, 16'h0055, 0);
    step(1, 16'h0066, 0);
    step(1, 16'h0077, 1);
    for (int i = 0; i < 10; i++)
      step(1, 16'h0100 + 16'(i), 1);
    repeat (6) step(0, 16'h0, 1);
    step(1, 16'h00aa, 0);
    step(1, 16'h00bb, 0);
    step(0, 16'h0, 1);

    do_reset();
    step(1, 16'h0a0a, 0);
    step(1, 16'h0b0b, 0);
    step(1, 16'h0c0c, 0);
    step(1, 16'h0d0d, 0);
    step(1, 16'h0e0e, 0);
    step(0, 16'h0, 0);
`ifdef DIN_BUF_OVERWRITE_EN
    chk("ovw_ovf", bus.OVERFLOW, 1);
    chk("ovw_num", bus.NUM_IN_BUF, 4);
    chk("ovw_radr", bus.DIN_OUT_RADR, 1);
`endif
    step(1, 16'h0f0f, 0);
    bus.DIN_VALID = 1'b1;
    do_reset();

    for (int i = 0; i < 600; i++) begin
      bit v, p;
      if (i % 150 == 149) begin
        bus.DIN_VALID = 1'b1;
        do_reset();
      end
      v = ($urandom_range(0, 99) < ((i / 50) % 2 ? 35 : 70));
      p = ($urandom_range(0, 99) < ((i / 50) % 2 ? 70 : 35));
      step(v, 16'($urandom), p);
    end

    chk_regs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
